// File: rtl/mvu_pkg.sv
// Shared CSR map, read-FSM state type and parameter defaults for the MVU APB CSR bank.
package mvu_pkg;

  localparam int MVU_NMVU_DEF      = 8;
  localparam int MVU_AW_DEF        = 15;
  localparam int MVU_CSR_WORDS_DEF = 96;

  // Slot indices within each MVU's CSR window; all other slots are plain storage
  typedef enum logic [11:0] {
    CSR_MVUCOMMAND  = 12'h000,
    CSR_MVUWBASEPTR = 12'h001,
    CSR_MVUSTATUS   = 12'h002,
    CSR_MVUIRQ      = 12'h003
  } mvu_csr_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } rd_state_t;

endpackage

// File: rtl/mvu_apb_csrbank_if.sv
// APB completer-side bus bundle for the MVU CSR bank.
interface mvu_apb_csrbank_if #(
  parameter int AW = 15
) ();
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/mvu_apb_rdfsm.sv
// APB response generator: zero-wait write completion and a two-stage registered read.
// state   | meaning
// RD_IDLE | no read in flight; writes complete here in their first access cycle
// RD_WAIT | read accepted, pready=0, read data and error captured
// RD_RESP | pready=1, captured data and error driven
module mvu_apb_rdfsm
  import mvu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic        err,
  input  logic [31:0] rdata,
  output logic        pready,
  output logic        pslverr,
  output logic [31:0] prdata,
  output logic        wr_en
);

  rd_state_t   state_q, state_d;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        access;

  assign access = psel && penable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RD_IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RD_WAIT) begin
        rdata_q <= rdata;
        err_q   <= err;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE: if (access && !pwrite) state_d = RD_WAIT;
      RD_WAIT: state_d = psel ? RD_RESP : RD_IDLE;
      RD_RESP: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  // rst gates the write path so nothing completes while reset is held
  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    wr_en   = 1'b0;
    unique case (state_q)
      RD_IDLE: if (access && pwrite && !rst) begin
        pready  = 1'b1;
        pslverr = err;
        wr_en   = !err;
      end
      RD_RESP: if (psel) begin
        pready  = 1'b1;
        pslverr = err_q;
        prdata  = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mvu_apb_csrbank.sv
// Per-MVU CSR storage with command start pulses and busy tracking behind an APB port.
// Optional sticky done interrupt per MVU when MVU_CSRBANK_IRQ_EN is defined.
module mvu_apb_csrbank
  import mvu_pkg::*;
#(
  parameter int NMVU           = MVU_NMVU_DEF,
  parameter int APB_ADDR_WIDTH = MVU_AW_DEF,
  parameter int CSR_WORDS      = MVU_CSR_WORDS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  mvu_apb_csrbank_if.slave    apb,
  output logic [31:0]         csr_q [NMVU][CSR_WORDS],
  output logic [NMVU-1:0]     mvu_start,
  input  logic [NMVU-1:0]     mvu_done
`ifdef MVU_CSRBANK_IRQ_EN
  ,
  output logic [NMVU-1:0]     mvu_irq
`endif
);

  localparam int IDW = (NMVU > 1) ? $clog2(NMVU) : 1;
  localparam int IXW = (CSR_WORDS > 1) ? $clog2(CSR_WORDS) : 1;

  logic [APB_ADDR_WIDTH-13:0] mvu_id;
  logic [11:0]                csr_idx;
  logic [IDW-1:0]             mid;
  logic [IXW-1:0]             cix;
  logic                       id_ok, ix_ok, is_cmd, is_status, is_irq, busy_sel;
  logic                       err, wr_en, store_en;
  logic [31:0]                rdata;
  logic [NMVU-1:0]            start_q, start_d, busy_q, busy_d;

  assign mvu_id    = apb.paddr[APB_ADDR_WIDTH-1:12];
  assign csr_idx   = apb.paddr[11:0];
  assign mid       = mvu_id[IDW-1:0];
  assign cix       = csr_idx[IXW-1:0];
  assign id_ok     = 32'(mvu_id) < 32'(NMVU);
  assign ix_ok     = 32'(csr_idx) < 32'(CSR_WORDS);
  assign is_cmd    = csr_idx == CSR_MVUCOMMAND;
  assign is_status = csr_idx == CSR_MVUSTATUS;
  assign is_irq    = csr_idx == CSR_MVUIRQ;
  assign busy_sel  = id_ok ? busy_q[mid] : 1'b0;

  assign err = !id_ok || !ix_ok || (apb.pwrite && (is_status || (is_cmd && busy_sel)));

  mvu_apb_rdfsm u_rdfsm (
    .clk     (clk),
    .rst     (rst),
    .psel    (apb.psel),
    .penable (apb.penable),
    .pwrite  (apb.pwrite),
    .err     (err),
    .rdata   (rdata),
    .pready  (apb.pready),
    .pslverr (apb.pslverr),
    .prdata  (apb.prdata),
    .wr_en   (wr_en)
  );

`ifdef MVU_CSRBANK_IRQ_EN
  logic [NMVU-1:0] pending_q, pending_d, w1c;

  assign w1c       = (wr_en && is_irq && apb.pwdata[0]) ? (NMVU'(1) << mid) : '0;
  assign pending_d = (pending_q & ~w1c) | mvu_done;
  assign mvu_irq   = pending_q;
  assign store_en  = !is_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end
`else
  assign store_en = 1'b1;
`endif

  always_comb begin
    rdata = '0;
    if (id_ok && ix_ok) begin
      if (is_status) rdata = {31'b0, busy_q[mid]};
`ifdef MVU_CSRBANK_IRQ_EN
      else if (is_irq) rdata = {31'b0, pending_q[mid]};
`endif
      else rdata = csr_q[mid][cix];
    end
  end

  // A start set and a done in the same cycle leave the MVU busy
  assign start_d   = (wr_en && is_cmd) ? (NMVU'(1) << mid) : '0;
  assign busy_d    = (busy_q & ~mvu_done) | start_d;
  assign mvu_start = start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NMVU; i++)
        for (int j = 0; j < CSR_WORDS; j++)
          csr_q[i][j] <= '0;
      start_q <= '0;
      busy_q  <= '0;
    end else begin
      if (wr_en && store_en) csr_q[mid][cix] <= apb.pwdata;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_mvu_apb_csrbank.sv
// Directed self-checking bench for mvu_apb_csrbank (NMVU=8, 16-bit paddr, 96 words).
module tb_mvu_apb_csrbank;
  import mvu_pkg::*;

  localparam int AW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] csr_q [8][96];
  logic [7:0]  mvu_start;
  logic [7:0]  mvu_done = '0;
`ifdef MVU_CSRBANK_IRQ_EN
  logic [7:0]  mvu_irq;
`endif
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_multi = 0;

  mvu_apb_csrbank_if #(.AW(AW)) apb ();

  mvu_apb_csrbank #(.NMVU(8), .APB_ADDR_WIDTH(AW), .CSR_WORDS(96)) dut (
    .clk       (clk),
    .rst       (rst),
    .apb       (apb.slave),
    .csr_q     (csr_q),
    .mvu_start (mvu_start),
    .mvu_done  (mvu_done)
`ifdef MVU_CSRBANK_IRQ_EN
    ,
    .mvu_irq   (mvu_irq)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if ($countones(mvu_start) > 1) n_multi++;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] adr(input int id, input int idx);
    return {4'(id), 12'(idx)};
  endfunction

  task automatic apb_idle();
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_wr(input logic [15:0] a, input logic [31:0] d, input logic [7:0] done_v,
                        output logic rdy, output logic err);
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0; apb.paddr = a; apb.pwdata = d;
    @(posedge clk); #1;
    apb.penable = 1'b1; mvu_done = done_v;
    @(negedge clk);
    rdy = apb.pready; err = apb.pslverr;
    @(posedge clk); #1;
    apb_idle(); mvu_done = '0;
  endtask

  task automatic wr_chk(input string tag, input logic [15:0] a, input logic [31:0] d, input logic exp_err);
    logic rdy, err;
    apb_wr(a, d, 8'h00, rdy, err);
    chk({tag, "_pready"}, 32'(rdy), 32'd1);
    chk({tag, "_pslverr"}, 32'(err), 32'(exp_err));
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp_d, input logic exp_err);
    logic [31:0] d;
    logic        err, first, got;
    d = '0; err = 1'b0; got = 1'b0; first = 1'b0;
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.pwrite = 1'b0; apb.penable = 1'b0; apb.paddr = a;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) first = apb.pready;
      if (apb.pready) begin
        got = 1'b1; d = apb.prdata; err = apb.pslverr;
        break;
      end
    end
    @(posedge clk); #1;
    apb_idle();
    chk({tag, "_first_pready"}, 32'(first), 32'd0);
    chk({tag, "_completed"}, 32'(got), 32'd1);
    chk({tag, "_prdata"}, d, exp_d);
    chk({tag, "_pslverr"}, 32'(err), 32'(exp_err));
  endtask

  task automatic done_pulse(input logic [7:0] v);
    @(posedge clk); #1; mvu_done = v;
    @(posedge clk); #1; mvu_done = '0;
  endtask

  initial begin
    logic rdy, err;
    apb_idle(); apb.paddr = '0; apb.pwdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pready", 32'(apb.pready), 32'd0);
    chk("rst_pslverr", 32'(apb.pslverr), 32'd0);
    chk("rst_prdata", apb.prdata, 32'd0);
    chk("rst_start", 32'(mvu_start), 32'd0);
    chk("rst_csr", csr_q[3][1], 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // basic write then read-back
    wr_chk("wbase_wr", adr(3, CSR_MVUWBASEPTR), 32'h1234, 1'b0);
    chk("wbase_csr", csr_q[3][1], 32'h1234);
    rd_chk("wbase_rd", adr(3, CSR_MVUWBASEPTR), 32'h1234, 1'b0);

    // command start pulse, busy and done
    wr_chk("cmd2_wr", adr(2, CSR_MVUCOMMAND), 32'hA5, 1'b0);
    @(negedge clk); chk("cmd2_start", 32'(mvu_start), 32'h04);
    @(negedge clk); chk("cmd2_start_end", 32'(mvu_start), 32'h00);
    chk("cmd2_csr", csr_q[2][0], 32'hA5);
    rd_chk("stat2_busy", adr(2, CSR_MVUSTATUS), 32'd1, 1'b0);
    rd_chk("stat3_idle", adr(3, CSR_MVUSTATUS), 32'd0, 1'b0);
    done_pulse(8'h04);
    rd_chk("stat2_done", adr(2, CSR_MVUSTATUS), 32'd0, 1'b0);

    // command while busy is rejected
    wr_chk("cmd2b_wr", adr(2, CSR_MVUCOMMAND), 32'h11, 1'b0);
    wr_chk("cmd2c_busy", adr(2, CSR_MVUCOMMAND), 32'h22, 1'b1);
    @(negedge clk); chk("cmd2c_nostart", 32'(mvu_start), 32'h00);
    chk("cmd2c_csr", csr_q[2][0], 32'h11);
    wr_chk("stat_wr", adr(2, CSR_MVUSTATUS), 32'h1, 1'b1);
    rd_chk("stat2_still", adr(2, CSR_MVUSTATUS), 32'd1, 1'b0);
    done_pulse(8'h04);
    done_pulse(8'h04);
    rd_chk("stat2_clr", adr(2, CSR_MVUSTATUS), 32'd0, 1'b0);

    // setup phase alone has no effect
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0;
    apb.paddr = adr(6, CSR_MVUCOMMAND); apb.pwdata = 32'h77;
    @(negedge clk); chk("setup_pready", 32'(apb.pready), 32'd0);
    @(posedge clk); #1; apb_idle();
    @(negedge clk); chk("setup_nostart", 32'(mvu_start), 32'h00);
    chk("setup_csr", csr_q[6][0], 32'd0);

    // out-of-range accesses
    wr_chk("id9_wr", adr(9, 5), 32'hBAD0, 1'b1);
    chk("id9_csr", csr_q[1][5], 32'd0);
    rd_chk("id9_rd", adr(9, 5), 32'd0, 1'b1);
    wr_chk("idx96_wr", adr(0, 96), 32'hBAD1, 1'b1);
    rd_chk("idx96_rd", adr(0, 96), 32'd0, 1'b1);
    wr_chk("idx101_wr", adr(0, 12'h101), 32'hBAD2, 1'b1);
    chk("idx101_csr", csr_q[0][1], 32'd0);
    wr_chk("edge_wr", adr(7, 95), 32'hCAFEF00D, 1'b0);
    rd_chk("edge_rd", adr(7, 95), 32'hCAFEF00D, 1'b0);

    // psel dropped while the read is waiting
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.pwrite = 1'b0; apb.paddr = adr(7, 95);
    @(posedge clk); #1; apb.penable = 1'b1;
    @(posedge clk); #1; apb_idle();
    @(negedge clk); chk("drop_pready0", 32'(apb.pready), 32'd0);
    @(negedge clk); chk("drop_pready1", 32'(apb.pready), 32'd0);
    chk("drop_prdata", apb.prdata, 32'd0);

`ifdef MVU_CSRBANK_IRQ_EN
    done_pulse(8'h20);
    @(negedge clk); chk("irq5_set", 32'(mvu_irq), 32'h20);
    rd_chk("irq5_rd", adr(5, CSR_MVUIRQ), 32'd1, 1'b0);
    apb_wr(adr(5, CSR_MVUIRQ), 32'h1, 8'h20, rdy, err);
    chk("irq5_w1c_done_err", 32'(err), 32'd0);
    @(negedge clk); chk("irq5_w1c_done", 32'(mvu_irq), 32'h20);
    apb_wr(adr(5, CSR_MVUIRQ), 32'h1, 8'h00, rdy, err);
    @(negedge clk); chk("irq5_w1c", 32'(mvu_irq), 32'h00);
    rd_chk("irq5_rd_clr", adr(5, CSR_MVUIRQ), 32'd0, 1'b0);
`else
    wr_chk("irqw_wr", adr(5, CSR_MVUIRQ), 32'hDEADBEEF, 1'b0);
    chk("irqw_csr", csr_q[5][3], 32'hDEADBEEF);
    rd_chk("irqw_rd", adr(5, CSR_MVUIRQ), 32'hDEADBEEF, 1'b0);
`endif

    // reset during a write access aborts it
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0;
    apb.paddr = adr(4, CSR_MVUCOMMAND); apb.pwdata = 32'h99;
    @(posedge clk); #1; apb.penable = 1'b1; rst = 1'b1;
    @(negedge clk); chk("rstwr_pready", 32'(apb.pready), 32'd0);
    @(posedge clk); #1; apb_idle(); rst = 1'b0;
    @(negedge clk);
    chk("rstwr_csr", csr_q[4][0], 32'd0);
    chk("rstwr_nostart", 32'(mvu_start), 32'h00);

    // reset while the read FSM is in RD_WAIT
    wr_chk("pre_rst_wr", adr(3, CSR_MVUWBASEPTR), 32'h5555, 1'b0);
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.pwrite = 1'b0; apb.paddr = adr(3, CSR_MVUWBASEPTR);
    @(posedge clk); #1; apb.penable = 1'b1;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("rstrd_pready", 32'(apb.pready), 32'd0);
    chk("rstrd_pslverr", 32'(apb.pslverr), 32'd0);
    chk("rstrd_prdata", apb.prdata, 32'd0);
    chk("rstrd_csr", csr_q[3][1], 32'd0);
    @(posedge clk); #1; apb_idle(); rst = 1'b0;
    rd_chk("post_rst_rd", adr(3, CSR_MVUWBASEPTR), 32'd0, 1'b0);
    wr_chk("post_rst_wr", adr(3, CSR_MVUWBASEPTR), 32'h0F0F, 1'b0);
    rd_chk("post_rst_rd2", adr(3, CSR_MVUWBASEPTR), 32'h0F0F, 1'b0);

    chk("start_onehot", 32'(n_multi), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
